// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer write sequencer and arbiter.
package fb_pkg;

    localparam int ADDR_W_DEF      = 17;
    localparam int FB_SIZE_DEF     = 76800;
    localparam int PIX_PER_PKT_DEF = 320;

    // Packet sequencing states.
    typedef enum logic [1:0] {
        WAIT_ADDR = 2'd0,
        PIXELS    = 2'd1,
        DONE      = 2'd2
    } pkt_state_t;

    // One buffered pixel write: target address plus byte.
    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [7:0]            data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Single-port frame-buffer memory bus; the arbiter is the master.
interface frame_buffer_arbiter_if #(
    parameter int ADDR_W = 17
) ();
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/frame_buffer_arbiter_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (count_r == CNT_W'(0));
    assign full      = (count_r == CNT_W'(DEPTH));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign rdata     = store_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            store_r[wr_ptr_r] <= wdata;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/frame_buffer_arbiter.sv
// Sequences packet pixel bytes into the frame buffer through a write FIFO and
// shares the single memory port with display reads (reads win unless the FIFO
// is almost full).
module frame_buffer_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int FB_SIZE     = FB_SIZE_DEF,
    parameter int PIX_PER_PKT = PIX_PER_PKT_DEF,
    parameter int FIFO_DEPTH  = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  addr_axiov,
    input  logic [23:0]           addr,
    input  logic                  pixel_axiov,
    input  logic [7:0]            pixel,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [7:0]            rd_data,
    output logic                  pkt_done,
    output logic [15:0]           pkt_count,
    output logic [15:0]           drop_count,
    frame_buffer_arbiter_if.master mem
);
    localparam int IDX_W = $clog2(PIX_PER_PKT);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    pkt_state_t        state_r, state_n;
    logic [ADDR_W-1:0] base_r, base_n;
    logic [IDX_W-1:0]  idx_r, idx_n;
    logic [ADDR_W:0]   wr_addr_s;
    logic              in_range_s, last_s;
    logic              push_req_s, fsm_drop_s, done_s;
    logic              push_s, pop_s, ovf_drop_s, drop_s;
    logic              rd_accept_s, almost_full_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    fifo_entry_t       fifo_in_s, fifo_out_s;
    logic              mem_en_r, mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;
    logic [15:0]       pkt_count_r, drop_count_r;
    logic [MEM_LATENCY:0] rv_pipe_r;
    logic              unused_addr_hi_s;

    assign unused_addr_hi_s = ^addr[23:ADDR_W];

    // Address is formed one bit wider so an overrun past FB_SIZE is visible.
    assign wr_addr_s  = {1'b0, base_r} + (ADDR_W+1)'(idx_r);
    assign in_range_s = (wr_addr_s < (ADDR_W+1)'(FB_SIZE));
    assign last_s     = (idx_r == IDX_W'(PIX_PER_PKT-1));
    assign fifo_in_s  = '{addr: wr_addr_s[ADDR_W-1:0], data: pixel};

    // Packet FSM: next state, index advance, push/drop/done decisions.
    always_comb begin
        state_n    = state_r;
        base_n     = base_r;
        idx_n      = idx_r;
        push_req_s = 1'b0;
        fsm_drop_s = 1'b0;
        done_s     = 1'b0;
        if (addr_axiov) begin
            state_n    = PIXELS;
            base_n     = addr[ADDR_W-1:0];
            idx_n      = IDX_W'(0);
            fsm_drop_s = pixel_axiov;
        end else if (pixel_axiov) begin
            case (state_r)
                PIXELS: begin
                    idx_n = idx_r + IDX_W'(1);
                    if (in_range_s) begin
                        push_req_s = 1'b1;
                    end else begin
                        fsm_drop_s = 1'b1;
                    end
                    if (last_s) begin
                        done_s  = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = PIXELS;
                    end
                end
                default: fsm_drop_s = 1'b1;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Packet FSM registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WAIT_ADDR;
            base_r  <= {ADDR_W{1'b0}};
            idx_r   <= IDX_W'(0);
        end else begin
            state_r <= state_n;
            base_r  <= base_n;
            idx_r   <= idx_n;
        end
    end

    // Arbitration: reads first, but back off once the FIFO is nearly full.
    assign almost_full_s = (fifo_count_s >= CNT_W'(FIFO_DEPTH-2));
    assign rd_ready      = !almost_full_s && !rst;
    assign rd_accept_s   = rd_req && rd_ready;
    assign pop_s         = !rd_accept_s && !fifo_empty_s;
    assign push_s        = push_req_s && (!fifo_full_s || pop_s);
    assign ovf_drop_s    = push_req_s && fifo_full_s && !pop_s;
    assign drop_s        = fsm_drop_s || ovf_drop_s;
    assign pkt_done      = done_s && !rst;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (fifo_in_s),
        .pop   (pop_s),
        .rdata (fifo_out_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Registered memory command from this cycle's arbitration result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 8'd0;
        end else begin
            mem_en_r <= rd_accept_s || pop_s;
            mem_we_r <= pop_s;
            if (rd_accept_s) begin
                mem_addr_r <= rd_addr;
            end else if (pop_s) begin
                mem_addr_r  <= fifo_out_s.addr;
                mem_wdata_r <= fifo_out_s.data;
            end else begin
                mem_addr_r <= mem_addr_r;
            end
        end
    end

    // Packet and drop statistics; drops saturate, packets wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_r  <= 16'd0;
            drop_count_r <= 16'd0;
        end else begin
            if (done_s) begin
                pkt_count_r <= pkt_count_r + 16'd1;
            end
            if (drop_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

    // Read-valid shift register: command stage plus memory latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rv_pipe_r <= {(MEM_LATENCY+1){1'b0}};
        end else begin
            rv_pipe_r <= {rv_pipe_r[MEM_LATENCY-1:0], rd_accept_s};
        end
    end

    assign rd_valid      = rv_pipe_r[MEM_LATENCY];
    assign rd_data       = rd_valid ? mem.mem_rdata : 8'd0;
    assign pkt_count     = pkt_count_r;
    assign drop_count    = drop_count_r;
    assign mem.mem_en    = mem_en_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;
endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Sequences pixel bytes arriving from the Ethernet image/audio splitter into the single-port frame-buffer BRAM and shares that port with the display read path. Per packet, it latches the 24-bit start address and computes a write address for each pixel byte. It buffers the writes in a small FIFO and arbitrates them against display reads, with reads normally taking priority. It sits between the splitter outputs and the frame-buffer memory, alongside the VGA/HDMI pixel fetcher.

## Interface
Parameters:
- ADDR_W, 17: frame-buffer address width.
- FB_SIZE, 76800: number of valid frame-buffer locations (320x240).
- PIX_PER_PKT, 320: pixel bytes per packet.
- FIFO_DEPTH, 16: write FIFO entries (power of two).
- MEM_LATENCY, 2: cycles from mem_en to valid mem_rdata.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (50 MHz Ethernet domain).
- rst  in  1  synchronous active-high reset.
- addr_axiov  in  1  one-cycle pulse: packet start address valid.
- addr  in  24  packet start address.
- pixel_axiov  in  1  one-cycle pulse: pixel byte valid.
- pixel  in  8  pixel byte.
- rd_req  in  1  display read request.
- rd_addr  in  ADDR_W  display read address.
- rd_ready  out  1  read accepted this cycle if rd_req is high; combinational.
- rd_valid  out  1  rd_data valid.
- rd_data  out  8  read data.
- mem_en  out  1  memory enable, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_wdata  out  8  memory write data, registered.
- mem_rdata  in  8  memory read data.
- pkt_done  out  1  one-cycle pulse when the last pixel of a packet is pushed.
- pkt_count  out  16  completed packets; wraps.
- drop_count  out  16  dropped pixel bytes; saturates at 0xFFFF.

## Operation
- **Packet FSM states:** WAIT_ADDR, PIXELS, DONE. Reset state is WAIT_ADDR.
  - addr_axiov in any state: base <= addr[ADDR_W-1:0], idx <= 0, go to PIXELS. A packet that was cut short is abandoned silently and pkt_count is not incremented.
  - In PIXELS, each pixel_axiov pushes {base+idx, pixel} into the FIFO and increments idx.
  - When the pushed pixel has idx == PIX_PER_PKT-1: pkt_done pulses in the same cycle as that push, pkt_count increments, and the FSM goes to DONE.
  - pixel_axiov in WAIT_ADDR or DONE: byte dropped, drop_count increments.
- **Address rule:** base+idx is computed at ADDR_W+1 bits. If the sum is >= FB_SIZE, the byte is dropped (drop_count increments, no push). There is no wrap-around.
- **FIFO overflow:** a push when the FIFO is full and no pop occurs in that cycle drops the byte (drop_count increments). Push and pop in the same cycle while full is legal.
- **Arbitration, each cycle:**
  - Define almost_full = fifo_count >= FIFO_DEPTH-2.
  - rd_ready = !almost_full.
  - If rd_req && rd_ready, issue a read.
  - Otherwise, if the FIFO is not empty, pop and issue a write.
  - Otherwise the memory port is idle.
  - A rd_req while rd_ready is low is not accepted. The requester holds the request.
- Simultaneous addr_axiov and pixel_axiov cannot occur (the splitter never issues them together). If it does happen, addr_axiov wins and the pixel is dropped.

## Timing
- **Reset values:** every output is 0. The FIFO is emptied, the FSM is in WAIT_ADDR, and base/idx are 0.
- **Memory command:** registered. mem_en/mem_we/mem_addr/mem_wdata are valid in the cycle after the arbitration decision.
- **Read latency:** rd_valid rises 1+MEM_LATENCY cycles after the accept cycle (3 by default). rd_data = mem_rdata in that cycle. Back-to-back reads give one result per cycle.
- **Write latency:** a pixel pushed at cycle t, into an empty FIFO with no read competing, appears on mem_we at t+2 (push at t, pop at t+1, registered command at t+2).
- **Reset mid-read:** the read-valid pipeline is flushed and no rd_valid is issued for reads in flight.
- **Write throughput:** pixels arrive at most 1 per 4 clk, so writes drain when reads load the port at 75% or less. almost_full bounds how long writes can be starved.

## Structure
- The shared package fb_pkg holds:
  - the packet FSM state typedef;
  - the FB_SIZE / PIX_PER_PKT defaults;
  - the packed FIFO entry struct {addr, data}.
- One sub-module: sync_fifo (parameterised width/depth, with count output, same clk/rst).
- Read-valid pipeline is a MEM_LATENCY+1 deep shift register inside the top level.

## Test plan
- **Single packet:** addr=0x000100 then 320 pixels (value = index) at 1 per 4 cycles, no reads.
  - mem writes to addresses 0x100..0x23F with matching data.
  - pkt_done pulses once; pkt_count=1; drop_count=0.
- **Read priority:** continuous rd_req at 50% duty during a packet.
  - Every accepted read returns rd_valid exactly 3 cycles later with model data.
  - All 320 writes complete; no drops.
- **Starvation guard:** rd_req held high for the whole packet.
  - rd_ready drops when the FIFO reaches 14 and writes proceed.
  - FIFO never overflows; drop_count=0.
- **Boundary address:** addr=76700, 320 pixels.
  - Only 100 writes occur (76700..76799); drop_count=220; pkt_done still pulses.
- **Truncated packet and stray pixels:**
  - 5 pixels before any addr are dropped (drop_count=5).
  - addr, 10 pixels, then a new addr: second packet starts at idx 0; pkt_count unchanged until the second packet completes.
- **Reset mid-operation:** assert rst with the FIFO half full and 2 reads in flight.
  - Next cycle all outputs are 0; no further mem_en or rd_valid until new stimulus.
